// File: rtl/dev_io_uart_if.sv
// if_io character interface between the control unit (master) and the UART server (slave).
interface dev_io_uart_if;
    logic       putc_push;
    logic [7:0] putc_char;
    logic       getc_pop;
    logic       getc_en;
    logic [7:0] getc_char;

    modport master (
        output putc_push,
        output putc_char,
        output getc_pop,
        input  getc_en,
        input  getc_char
    );

    modport slave (
        input  putc_push,
        input  putc_char,
        input  getc_pop,
        output getc_en,
        output getc_char
    );
endinterface

// File: rtl/dev_io_uart.sv
// UART server for the if_io port: TX FIFO + 8N1 serialiser, RX deserialiser + FWFT RX FIFO.
// Optional IO_UART_LOOPBACK_EN feeds the RX synchroniser from the internal uart_tx register.
module dev_io_uart #(
    parameter int unsigned CLK_FREQ   = 12000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    dev_io_uart_if.slave io,
    output logic         uart_tx,
    input  logic         uart_rx,
    output logic         tx_busy,
    output logic         rx_overrun,
    output logic         rx_frame_err
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W        = AW + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    // ---------------- TX FIFO ----------------
    logic [7:0]       tx_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wr_q;
    logic [PTR_W-1:0] tx_rd_q;
    logic             tx_empty_c;
    logic             tx_full_c;
    logic             tx_push_c;

    assign tx_empty_c = (tx_wr_q == tx_rd_q);
    assign tx_full_c  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
    assign tx_push_c  = io.putc_push && !tx_full_c;

    always_ff @(posedge clk) begin
        if (tx_push_c) tx_mem_q[tx_wr_q[AW-1:0]] <= io.putc_char;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           tx_wr_q <= '0;
        else if (tx_push_c) tx_wr_q <= tx_wr_q + PTR_W'(1);
    end

    // ---------------- TX serialiser ----------------
    tx_state_e        tx_state_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [2:0]       tx_bit_q;
    logic [7:0]       tx_shift_q;
    logic             uart_tx_q;
    logic             tx_busy_q;

    // Line level lags the state by one cycle, so every bit still lasts CLKS_PER_BIT cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_rd_q    <= '0;
            uart_tx_q  <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_busy_q <= !tx_empty_c || (tx_state_q != TX_IDLE);
            case (tx_state_q)
                TX_START: uart_tx_q <= 1'b0;
                TX_DATA:  uart_tx_q <= tx_shift_q[0];
                default:  uart_tx_q <= 1'b1;
            endcase
            case (tx_state_q)
                TX_IDLE: begin
                    tx_cnt_q <= '0;
                    if (!tx_empty_c) begin
                        tx_shift_q <= tx_mem_q[tx_rd_q[AW-1:0]];
                        tx_rd_q    <= tx_rd_q + PTR_W'(1);
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        if (tx_bit_q == 3'd7) tx_state_q <= TX_STOP;
                        else                  tx_bit_q   <= tx_bit_q + 3'd1;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_state_q <= TX_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign uart_tx = uart_tx_q;
    assign tx_busy = tx_busy_q;

    // ---------------- RX synchroniser ----------------
    logic rx_src_c;
    logic rx_meta_q;
    logic rx_sync_q;
    logic rx_prev_q;

`ifdef IO_UART_LOOPBACK_EN
    logic rx_pin_unused;
    assign rx_src_c      = uart_tx_q;
    assign rx_pin_unused = uart_rx;
`else
    assign rx_src_c = uart_rx;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_src_c;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]       rx_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rx_wr_q;
    logic [PTR_W-1:0] rx_rd_q;
    logic             rx_empty_c;
    logic             rx_full_c;
    logic             rx_pop_c;
    logic             rx_push_req_c;
    logic             rx_push_c;

    rx_state_e        rx_state_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_shift_q;
    logic             rx_wait_q;
    logic             rx_overrun_q;
    logic             rx_frame_err_q;

    assign rx_empty_c    = (rx_wr_q == rx_rd_q);
    assign rx_full_c     = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
    assign rx_pop_c      = io.getc_pop && !rx_empty_c;
    assign rx_push_req_c = (rx_state_q == RX_STOP) && !rx_wait_q && (rx_cnt_q == BIT_LAST) && rx_sync_q;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign rx_push_c     = rx_push_req_c && (!rx_full_c || rx_pop_c);

    always_ff @(posedge clk) begin
        if (rx_push_c) rx_mem_q[rx_wr_q[AW-1:0]] <= rx_shift_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wr_q <= '0;
            rx_rd_q <= '0;
        end else begin
            if (rx_push_c) rx_wr_q <= rx_wr_q + PTR_W'(1);
            if (rx_pop_c)  rx_rd_q <= rx_rd_q + PTR_W'(1);
        end
    end

    assign io.getc_en   = !rx_empty_c;
    assign io.getc_char = rx_empty_c ? 8'h00 : rx_mem_q[rx_rd_q[AW-1:0]];

    // ---------------- RX deserialiser ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q     <= RX_IDLE;
            rx_cnt_q       <= '0;
            rx_bit_q       <= '0;
            rx_shift_q     <= '0;
            rx_wait_q      <= 1'b0;
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            if (rx_push_req_c && rx_full_c && !rx_pop_c) rx_overrun_q <= 1'b1;
            case (rx_state_q)
                RX_IDLE: begin
                    rx_cnt_q  <= '0;
                    rx_wait_q <= 1'b0;
                    if (rx_prev_q && !rx_sync_q) rx_state_q <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    // After a framing error, hold here until the line returns high.
                    if (rx_wait_q) begin
                        if (rx_sync_q) begin
                            rx_wait_q  <= 1'b0;
                            rx_state_q <= RX_IDLE;
                        end
                    end else if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q <= '0;
                        if (rx_sync_q) begin
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_frame_err_q <= 1'b1;
                            rx_wait_q      <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_overrun   = rx_overrun_q;
    assign rx_frame_err = rx_frame_err_q;

endmodule

// File: tb/tb_dev_io_uart.sv
// Self-checking bench for dev_io_uart: randomized TX/RX traffic against a queue-based reference model.
module tb_dev_io_uart;
    localparam int unsigned CLK_FREQ = 16;
    localparam int unsigned BAUD     = 1;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned CPB      = CLK_FREQ / BAUD;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic uart_tx;
    logic uart_rx;
    logic tx_busy;
    logic rx_overrun;
    logic rx_frame_err;

    dev_io_uart_if io ();

    dev_io_uart #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .io          (io),
        .uart_tx     (uart_tx),
        .uart_rx     (uart_rx),
        .tx_busy     (tx_busy),
        .rx_overrun  (rx_overrun),
        .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] tx_seen  [$];
    logic [7:0] rx_model [$];
    logic       ovr_exp  = 1'b0;
    logic       ferr_exp = 1'b0;
    logic       mon_en   = 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line monitor: decodes 8N1 frames from uart_tx by mid-bit sampling.
    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(negedge uart_tx);
            repeat (CPB / 2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1 b[i] = uart_tx;
            end
            repeat (CPB) @(posedge clk);
            if (mon_en) tx_seen.push_back(b);
        end
    end

    task automatic wait_tx_idle();
        int n = 0;
        while (tx_busy !== 1'b0 && n < 3000) begin
            tick();
            n++;
        end
        total++;
        if (n >= 3000) begin
            bad++;
            $display("FAIL tx_idle_timeout: tx_busy=%b after %0d cycles, required 0", tx_busy, n);
        end
        repeat (20) tick();
    endtask

    // Drive one 8N1 frame on uart_rx and update the reference model.
    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            uart_rx = fr[k];
            repeat (CPB) tick();
        end
        if (!stop) begin
            repeat (CPB) tick();
            uart_rx = 1'b1;
            repeat (CPB) tick();
            ferr_exp = 1'b1;
        end else if (rx_model.size() < DEPTH) begin
            rx_model.push_back(b);
        end else begin
            ovr_exp = 1'b1;
        end
        repeat (2) tick();
    endtask

    task automatic pop_check(input string name);
        logic [7:0] e;
        e = rx_model.pop_front();
        total++;
        if (io.getc_en !== 1'b1 || io.getc_char !== e) begin
            bad++;
            $display("FAIL %s: getc_en=%b getc_char=%h, required 1/%h", name, io.getc_en, io.getc_char, e);
        end
        io.getc_pop = 1'b1;
        tick();
        io.getc_pop = 1'b0;
    endtask

    task automatic check_rx_state(input string name);
        total++;
        if (io.getc_en !== (rx_model.size() != 0) || rx_overrun !== ovr_exp || rx_frame_err !== ferr_exp) begin
            bad++;
            $display("FAIL %s: en/ovr/ferr=%b%b%b, required %b%b%b", name, io.getc_en, rx_overrun,
                     rx_frame_err, rx_model.size() != 0, ovr_exp, ferr_exp);
        end
    endtask

    task automatic test_reset();
        total++;
        if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_tx: uart_tx=%b tx_busy=%b, required 1/0", uart_tx, tx_busy);
        end
        total++;
        if (io.getc_en !== 1'b0 || io.getc_char !== 8'h00) begin
            bad++;
            $display("FAIL reset_rx: getc_en=%b getc_char=%h, required 0/00", io.getc_en, io.getc_char);
        end
        total++;
        if (rx_overrun !== 1'b0 || rx_frame_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: ovr=%b ferr=%b, required 0/0", rx_overrun, rx_frame_err);
        end
    endtask

    // Exact waveform of one frame: start 2 cycles after the push edge, CPB cycles per bit.
    task automatic test_tx_single();
        logic [9:0] fr;
        logic [9:0] bit_bad;
        logic       pre_bad;
        logic       busy_mid;
        logic       busy_end;
        fr       = {1'b1, 8'h41, 1'b0};
        bit_bad  = '0;
        pre_bad  = 1'b0;
        busy_mid = 1'b0;
        busy_end = 1'b1;
        io.putc_char = 8'h41;
        io.putc_push = 1'b1;
        tick();
        io.putc_push = 1'b0;
        for (int c = 1; c <= 170; c++) begin
            int k;
            tick();
            k = (c - 2) / int'(CPB);
            if (c < 2) begin
                if (uart_tx !== 1'b1) pre_bad = 1'b1;
            end else if (k < 10) begin
                if (uart_tx !== fr[k]) bit_bad[k] = 1'b1;
            end else if (uart_tx !== 1'b1) begin
                pre_bad = 1'b1;
            end
            if (c == 150) busy_mid = tx_busy;
            if (c == 166) busy_end = tx_busy;
        end
        total++;
        if (pre_bad !== 1'b0) begin
            bad++;
            $display("FAIL tx_single_idle: line not high outside the frame, required 1");
        end
        for (int k = 0; k < 10; k++) begin
            total++;
            if (bit_bad[k] !== 1'b0) begin
                bad++;
                $display("FAIL tx_single_bit%0d: line deviated from required %b", k, fr[k]);
            end
        end
        total++;
        if (busy_mid !== 1'b1 || busy_end !== 1'b0) begin
            bad++;
            $display("FAIL tx_single_busy: mid=%b end=%b, required 1/0", busy_mid, busy_end);
        end
        wait_tx_idle();
    endtask

    // An idle transmitter moves the first byte to its shifter, so a burst keeps DEPTH+1 bytes.
    task automatic run_burst(input int n);
        logic [7:0] exp_q [$];
        logic [7:0] b;
        tx_seen.delete();
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (i < int'(DEPTH) + 1) exp_q.push_back(b);
            io.putc_char = b;
            io.putc_push = 1'b1;
            tick();
        end
        io.putc_push = 1'b0;
        wait_tx_idle();
        total++;
        if (tx_seen.size() != exp_q.size()) begin
            bad++;
            $display("FAIL tx_burst_count: sent %0d, required %0d", tx_seen.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= tx_seen.size() || tx_seen[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL tx_burst_byte%0d: got %h, required %h", i,
                         (i < tx_seen.size()) ? tx_seen[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_tx_burst();
        run_burst(5);
        run_burst(6);
        run_burst(int'($urandom_range(1, 7)));
    endtask

    task automatic test_rx_single();
        logic [9:0] fr;
        int         lat;
        fr  = {1'b1, 8'hA5, 1'b0};
        lat = -1;
        for (int c = 0; c < 200; c++) begin
            uart_rx = (c / int'(CPB) < 10) ? fr[c / int'(CPB)] : 1'b1;
            tick();
            if (lat < 0 && io.getc_en === 1'b1) lat = c;
        end
        rx_model.push_back(8'hA5);
        total++;
        if (lat < 145 || lat > 170) begin
            bad++;
            $display("FAIL rx_single_latency: %0d cycles, required about %0d", lat, 10 * CPB);
        end
        pop_check("rx_single_char");
        check_rx_state("rx_single_after_pop");
    endtask

    task automatic test_rx_glitch();
        uart_rx = 1'b0;
        repeat (4) tick();
        uart_rx = 1'b1;
        repeat (40) tick();
        check_rx_state("rx_glitch");
    endtask

    task automatic test_rx_stream();
        for (int i = 0; i < 8; i++) begin
            send_rx(8'($urandom), 1'b1);
            if (rx_model.size() == DEPTH || $urandom_range(0, 1) == 1) pop_check("rx_stream_pop");
        end
        while (rx_model.size() != 0) pop_check("rx_stream_drain");
        check_rx_state("rx_stream_empty");
    endtask

    task automatic test_rx_frame_err();
        send_rx(8'($urandom), 1'b0);
        check_rx_state("rx_frame_err");
        send_rx(8'($urandom), 1'b1);
        pop_check("rx_frame_recover");
    endtask

    task automatic test_rx_overrun();
        for (int i = 0; i < 5; i++) begin
            send_rx(8'($urandom), 1'b1);
            if (i == 3) check_rx_state("rx_full_no_overrun");
        end
        check_rx_state("rx_overrun");
        for (int i = 0; i < 4; i++) pop_check("rx_overrun_pop");
        check_rx_state("rx_overrun_empty");
    endtask

    task automatic test_loopback();
        logic [7:0] b;
        int         n;
        b = 8'($urandom);
        n = 0;
        uart_rx = 1'b0;
        io.putc_char = b;
        io.putc_push = 1'b1;
        tick();
        io.putc_push = 1'b0;
        while (io.getc_en !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        rx_model.push_back(b);
        pop_check("loopback_char");
        check_rx_state("loopback_flags");
        wait_tx_idle();
    endtask

    task automatic test_reset_midframe();
        logic hold_bad;
        hold_bad = 1'b0;
`ifndef IO_UART_LOOPBACK_EN
        send_rx(8'($urandom), 1'b1);
        check_rx_state("midreset_rx_loaded");
`endif
        mon_en = 1'b0;
        io.putc_char = 8'h00;
        io.putc_push = 1'b1;
        tick();
        io.putc_push = 1'b0;
        repeat (40) tick();
        total++;
        if (uart_tx !== 1'b0 || tx_busy !== 1'b1) begin
            bad++;
            $display("FAIL midreset_inframe: uart_tx=%b busy=%b, required 0/1", uart_tx, tx_busy);
        end
        #3 rst = 1'b0;
        #1;
        rx_model.delete();
        ovr_exp  = 1'b0;
        ferr_exp = 1'b0;
        total++;
        if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || io.getc_char !== 8'h00) begin
            bad++;
            $display("FAIL midreset_async: uart_tx=%b busy=%b char=%h, required 1/0/00",
                     uart_tx, tx_busy, io.getc_char);
        end
        check_rx_state("midreset_rx_cleared");
        tick();
        rst = 1'b1;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) hold_bad = 1'b1;
        end
        total++;
        if (hold_bad !== 1'b0) begin
            bad++;
            $display("FAIL midreset_aborted: line/busy active after reset, required idle");
        end
    endtask

    initial begin
        uart_rx      = 1'b1;
        io.putc_push = 1'b0;
        io.putc_char = 8'h00;
        io.getc_pop  = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        test_reset();
        test_tx_single();
        test_tx_burst();
`ifdef IO_UART_LOOPBACK_EN
        test_loopback();
`else
        test_rx_single();
        test_rx_glitch();
        test_rx_stream();
        test_rx_frame_err();
        test_rx_overrun();
`endif
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
